// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle for the shared-ALU arbiter.
// The arbiter connects through slave; its environment uses master.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_in1;
    logic [DATA_W-1:0] req0_in2;
    logic [FUNC_W-1:0] req0_func;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_in1;
    logic [DATA_W-1:0] req1_in2;
    logic [FUNC_W-1:0] req1_func;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [FUNC_W-1:0] alu_func;
    logic [DATA_W-1:0] alu_out;
    logic              alu_z;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_z;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_func,
        output req0_ready,
        input  req1_valid, req1_in1, req1_in2, req1_func,
        output req1_ready,
        output alu_in1, alu_in2, alu_func,
        input  alu_out, alu_z,
        output rsp_valid, rsp_id, rsp_data, rsp_z,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_func,
        input  req0_ready,
        output req1_valid, req1_in1, req1_in2, req1_func,
        input  req1_ready,
        input  alu_in1, alu_in2, alu_func,
        output alu_out, alu_z,
        input  rsp_valid, rsp_id, rsp_data, rsp_z,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// one operation in flight, result returned on a tagged response channel.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
    logic [FUNC_W-1:0] alu_func_q, alu_func_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_z_q, rsp_z_d;
    logic              grant0, grant1;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        alu_in1_d  = alu_in1_q;
        alu_in2_d  = alu_in2_q;
        alu_func_d = alu_func_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_z_d    = rsp_z_q;
        grant0     = 1'b0;
        grant1     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // prio only matters when both requesters contend
                grant0 = !rst && bus.req0_valid
                       && (!bus.req1_valid || !prio_q);
                grant1 = !rst && bus.req1_valid && !grant0;
                if (grant0) begin
                    alu_in1_d  = bus.req0_in1;
                    alu_in2_d  = bus.req0_in2;
                    alu_func_d = bus.req0_func;
                    rsp_id_d   = 1'b0;
                    prio_d     = 1'b1;
                    state_d    = EXEC;
                end else if (grant1) begin
                    alu_in1_d  = bus.req1_in1;
                    alu_in2_d  = bus.req1_in2;
                    alu_func_d = bus.req1_func;
                    rsp_id_d   = 1'b1;
                    prio_d     = 1'b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = bus.alu_out;
                rsp_z_d    = bus.alu_z;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            alu_in1_q  <= '0;
            alu_in2_q  <= '0;
            alu_func_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_z_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            alu_in1_q  <= alu_in1_d;
            alu_in2_q  <= alu_in2_d;
            alu_func_q <= alu_func_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_z_q    <= rsp_z_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.alu_in1    = alu_in1_q;
    assign bus.alu_in2    = alu_in2_q;
    assign bus.alu_func   = alu_func_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_z      = rsp_z_q;
endmodule
